// File: rtl/mem_arbiter_if.sv
// Bus bundle between the MIPS fetch/data stages, the arbiter and the shared
// single-port memory. The arbiter connects through the slave modport; the
// requesters plus memory (or a testbench standing in for them) use master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              if_stall;

  // data-memory requester
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [3:0]        dm_be;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              dm_stall;

  // unified memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack, if_stall,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_rdata, dm_ack, dm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack, if_stall,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_rdata, dm_ack, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the
// data stage. Data wins ties, except when fetch has already watched
// STARVE_MAX consecutive data grants; then fetch is forced through.
// Each transaction goes IDLE -> GRANT_x -> IDLE, giving one bubble per access.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus_if
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic starve_hit;
  logic grant_d;
  logic grant_i;
  logic if_done;
  logic dm_done;
  logic dm_load_done;

  // Arbitration decision, only meaningful while IDLE
  always_comb begin
    starve_hit = bus_if.if_req && (starve_cnt_q == STARVE_LIM);
    grant_d    = (state_q == IDLE) && bus_if.dm_req && !starve_hit;
    grant_i    = (state_q == IDLE) && !grant_d && bus_if.if_req;
  end

  // State register; reset abandons any in-flight access without an ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: grant from IDLE, return to IDLE when memory completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = GRANT_D;
        end else if (grant_i) begin
          state_d = GRANT_I;
        end
      end
      GRANT_I: if (bus_if.mem_ready) state_d = IDLE;
      GRANT_D: if (bus_if.mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: acks and stalls are combinational so the pipeline can advance
  // in the very cycle the memory completes; read data bypasses the holding
  // register in that cycle
  always_comb begin
    if_done      = (state_q == GRANT_I) && bus_if.mem_ready;
    dm_done      = (state_q == GRANT_D) && bus_if.mem_ready;
    dm_load_done = dm_done && !mem_we_q;

    bus_if.if_ack   = if_done;
    bus_if.dm_ack   = dm_done;
    bus_if.if_rdata = if_done ? bus_if.mem_rdata : if_rdata_q;
    bus_if.dm_rdata = dm_load_done ? bus_if.mem_rdata : dm_rdata_q;
    bus_if.if_stall = bus_if.if_req && !if_done;
    bus_if.dm_stall = bus_if.dm_req && !dm_done;
  end

  // Datapath next state: load the memory command on the grant edge, hold it
  // until completion, capture read data and track fetch starvation
  always_comb begin
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    starve_cnt_d = starve_cnt_q;

    if (grant_d) begin
      mem_req_d   = 1'b1;
      mem_we_d    = bus_if.dm_we;
      mem_addr_d  = bus_if.dm_addr;
      mem_wdata_d = bus_if.dm_wdata;
      mem_be_d    = bus_if.dm_be;
      // Only a data grant that overtakes a waiting fetch counts against it
      if (bus_if.if_req && (starve_cnt_q != STARVE_LIM)) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end else if (grant_i) begin
      // Fetch leaves the write data register untouched
      mem_req_d    = 1'b1;
      mem_we_d     = 1'b0;
      mem_addr_d   = bus_if.if_addr;
      mem_be_d     = 4'hf;
      starve_cnt_d = 4'd0;
    end

    if (if_done || dm_done) begin
      mem_req_d = 1'b0;
    end
    if (if_done) begin
      if_rdata_d = bus_if.mem_rdata;
    end
    if (dm_load_done) begin
      dm_rdata_d = bus_if.mem_rdata;
    end
  end

  // Datapath registers; mem_req drops the instant reset asserts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= 4'h0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      starve_cnt_q <= 4'd0;
    end else begin
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus_if.mem_req   = mem_req_q;
  assign bus_if.mem_we    = mem_we_q;
  assign bus_if.mem_addr  = mem_addr_q;
  assign bus_if.mem_wdata = mem_wdata_q;
  assign bus_if.mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural memory with programmable wait states,
// requester drivers per scenario, and queues of expected read data filled
// when a request is issued and drained when the matching ack appears.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus_if(mif)
  );

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int wait_cycles = 0;
  bit tie_ready   = 1'b0;
  int mcnt        = 0;

  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] if_exp_q[$];
  logic [31:0] dm_exp_q[$];

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory model: completes a request after wait_cycles, or at once when
  // tie_ready is set; applies byte-enabled writes on the completing edge
  initial begin : mem_proc
    logic [31:0] w;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mif.mem_req && mif.mem_ready && mif.mem_we) begin
        w = model_read(mif.mem_addr);
        for (int b = 0; b < 4; b++)
          if (mif.mem_be[b]) w[8*b +: 8] = mif.mem_wdata[8*b +: 8];
        mem_model[mif.mem_addr] = w;
      end
      #2;
      if (!mif.mem_req) begin
        mcnt = 0;
        mif.mem_ready = tie_ready;
      end else begin
        mif.mem_ready = tie_ready || (mcnt >= wait_cycles);
        mcnt++;
      end
      mif.mem_rdata = mif.mem_ready ? model_read(mif.mem_addr) : 32'hBAD0_BAD0;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mif.mem_req); end
    checks++; if (mif.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mif.mem_we); end
    checks++; if (mif.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mif.mem_addr); end
    checks++; if (mif.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mif.mem_wdata); end
    checks++; if (mif.mem_be !== 4'h0) begin errors++; $display("FAIL reset_mem_be: got %h want 0", mif.mem_be); end
    checks++; if (mif.if_rdata !== 32'h0 || mif.dm_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", mif.if_rdata, mif.dm_rdata); end
    checks++; if (mif.if_ack !== 1'b0 || mif.dm_ack !== 1'b0) begin errors++; $display("FAIL reset_acks: got %b/%b want 0/0", mif.if_ack, mif.dm_ack); end
    checks++; if (mif.if_stall !== 1'b0 || mif.dm_stall !== 1'b0) begin errors++; $display("FAIL reset_stalls: got %b/%b want 0/0", mif.if_stall, mif.dm_stall); end
    reset = 1'b0;
  endtask

  task automatic test_single_fetch();
    bit seen;
    int acks;
    logic [31:0] exp;
    seen = 0; acks = 0;
    wait_cycles = 2;
    if_exp_q.push_back(32'h2008_0005);
    @(posedge clk); #1;
    mif.if_req = 1'b1; mif.if_addr = 32'h0040_0000;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mif.mem_req && !seen) begin
        seen = 1;
        checks++; if (mif.mem_addr !== 32'h0040_0000) begin errors++; $display("FAIL fetch_mem_addr: got %h want 00400000", mif.mem_addr); end
        checks++; if (mif.mem_be !== 4'hf || mif.mem_we !== 1'b0) begin errors++; $display("FAIL fetch_mem_be_we: got %h/%b want f/0", mif.mem_be, mif.mem_we); end
      end
      if (mif.if_ack) begin
        acks++;
        exp = (if_exp_q.size() > 0) ? if_exp_q.pop_front() : 32'hxxxx_xxxx;
        checks++; if (mif.if_rdata !== exp) begin errors++; $display("FAIL fetch_rdata: got %h want %h", mif.if_rdata, exp); end
        $display("txn IF  addr=%h data=%h cyc=%0d", mif.mem_addr, mif.if_rdata, cycle);
        @(posedge clk); #1;
        mif.if_req = 1'b0;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL fetch_timeout: got no mem_req want mem_req"); end
    checks++; if (acks != 1) begin errors++; $display("FAIL fetch_ack_count: got %0d want 1", acks); end
    checks++; if (mif.if_rdata !== 32'h2008_0005) begin errors++; $display("FAIL fetch_rdata_held: got %h want 20080005", mif.if_rdata); end
  endtask

  task automatic test_store_load();
    bit seen, done;
    logic [31:0] exp;
    seen = 0; done = 0;
    wait_cycles = 1;
    @(posedge clk); #1;
    mif.dm_req = 1'b1; mif.dm_we = 1'b1; mif.dm_addr = 32'h1000_0004;
    mif.dm_wdata = 32'hDEAD_BEEF; mif.dm_be = 4'h3;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (mif.mem_req && !seen) begin
        seen = 1;
        checks++; if (mif.mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_wdata: got %h want deadbeef", mif.mem_wdata); end
        checks++; if (mif.mem_be !== 4'h3 || mif.mem_we !== 1'b1) begin errors++; $display("FAIL store_be_we: got %h/%b want 3/1", mif.mem_be, mif.mem_we); end
      end
      if (mif.dm_ack) begin
        done = 1;
        checks++; if (mif.dm_rdata !== 32'h0) begin errors++; $display("FAIL store_rdata_unchanged: got %h want 0", mif.dm_rdata); end
        $display("txn DS  addr=%h wdata=%h be=%h cyc=%0d", mif.mem_addr, mif.mem_wdata, mif.mem_be, cycle);
        @(posedge clk); #1;
        mif.dm_req = 1'b0; mif.dm_we = 1'b0;
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL store_timeout: got no dm_ack want dm_ack"); end
    // 0x11223344 preloaded, low half overwritten by the store
    dm_exp_q.push_back(32'h1122_BEEF);
    done = 0;
    @(posedge clk); #1;
    mif.dm_req = 1'b1; mif.dm_we = 1'b0; mif.dm_addr = 32'h1000_0004;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (mif.dm_ack) begin
        done = 1;
        exp = dm_exp_q.pop_front();
        checks++; if (mif.dm_rdata !== exp) begin errors++; $display("FAIL load_rdata: got %h want %h", mif.dm_rdata, exp); end
        $display("txn DL  addr=%h data=%h cyc=%0d", mif.mem_addr, mif.dm_rdata, cycle);
        @(posedge clk); #1;
        mif.dm_req = 1'b0;
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL load_timeout: got no dm_ack want dm_ack"); end
    @(negedge clk);
    checks++; if (mif.dm_rdata !== 32'h1122_BEEF) begin errors++; $display("FAIL load_rdata_held: got %h want 1122beef", mif.dm_rdata); end
  endtask

  task automatic test_collision();
    logic [31:0] ia, da, exp;
    int first_grant, d_ack_cyc, i_grant_cyc, stall_bad;
    bit prev_req, i_done;
    ia = 32'h0040_0004; da = 32'h1000_0008;
    first_grant = -1; d_ack_cyc = -1; i_grant_cyc = -100; stall_bad = 0;
    prev_req = 0; i_done = 0;
    wait_cycles = 1;
    if_exp_q.push_back(model_read(ia));
    dm_exp_q.push_back(model_read(da));
    @(posedge clk); #1;
    mif.if_req = 1'b1; mif.if_addr = ia;
    mif.dm_req = 1'b1; mif.dm_we = 1'b0; mif.dm_addr = da;
    for (int c = 0; c < 40 && !i_done; c++) begin
      @(negedge clk);
      if (mif.mem_req && !prev_req) begin
        if (first_grant < 0) first_grant = (mif.mem_addr == da) ? 0 : 1;
        if (mif.mem_addr == ia) i_grant_cyc = cycle;
      end
      prev_req = mif.mem_req;
      if (mif.if_stall !== !mif.if_ack) stall_bad++;
      if (mif.dm_ack) begin
        d_ack_cyc = cycle;
        exp = (dm_exp_q.size() > 0) ? dm_exp_q.pop_front() : 32'hxxxx_xxxx;
        checks++; if (mif.dm_rdata !== exp) begin errors++; $display("FAIL coll_dm_rdata: got %h want %h", mif.dm_rdata, exp); end
        $display("txn DL  addr=%h data=%h cyc=%0d", mif.mem_addr, mif.dm_rdata, cycle);
        @(posedge clk); #1;
        mif.dm_req = 1'b0;
      end else if (mif.if_ack) begin
        i_done = 1;
        exp = if_exp_q.pop_front();
        checks++; if (mif.if_rdata !== exp) begin errors++; $display("FAIL coll_if_rdata: got %h want %h", mif.if_rdata, exp); end
        $display("txn IF  addr=%h data=%h cyc=%0d", mif.mem_addr, mif.if_rdata, cycle);
        @(posedge clk); #1;
        mif.if_req = 1'b0;
      end
    end
    checks++; if (!i_done) begin errors++; $display("FAIL coll_timeout: got no if_ack want if_ack"); end
    checks++; if (first_grant != 0) begin errors++; $display("FAIL coll_first_grant: got %0d want 0 (data)", first_grant); end
    checks++; if (i_grant_cyc - d_ack_cyc != 2) begin errors++; $display("FAIL coll_i_grant_gap: got %0d want 2", i_grant_cyc - d_ack_cyc); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL coll_if_stall: got %0d bad cycles want 0", stall_bad); end
  endtask

  task automatic test_starvation();
    logic [31:0] ia, da, exp;
    int d_grants;
    bit i_done, prev_req, i_granted;
    ia = 32'h0040_0100; da = 32'h1000_0100;
    d_grants = 0; i_done = 0; prev_req = 0; i_granted = 0;
    wait_cycles = 0;
    if_exp_q.push_back(model_read(ia));
    dm_exp_q.push_back(model_read(da));
    @(posedge clk); #1;
    mif.if_req = 1'b1; mif.if_addr = ia;
    mif.dm_req = 1'b1; mif.dm_we = 1'b0; mif.dm_addr = da;
    for (int c = 0; c < 100 && !i_done; c++) begin
      @(negedge clk);
      if (mif.mem_req && !prev_req) begin
        if (mif.mem_addr == ia && !mif.mem_we) i_granted = 1;
        else if (!i_granted) d_grants++;
      end
      prev_req = mif.mem_req;
      if (mif.dm_ack) begin
        exp = (dm_exp_q.size() > 0) ? dm_exp_q.pop_front() : 32'hxxxx_xxxx;
        checks++; if (mif.dm_rdata !== exp) begin errors++; $display("FAIL starve_dm_rdata: got %h want %h", mif.dm_rdata, exp); end
        $display("txn DL  addr=%h data=%h cyc=%0d", mif.mem_addr, mif.dm_rdata, cycle);
        @(posedge clk); #1;
        da = da + 32'd4;
        mif.dm_addr = da;
        dm_exp_q.push_back(model_read(da));
      end else if (mif.if_ack) begin
        i_done = 1;
        exp = if_exp_q.pop_front();
        checks++; if (mif.if_rdata !== exp) begin errors++; $display("FAIL starve_if_rdata: got %h want %h", mif.if_rdata, exp); end
        $display("txn IF  addr=%h data=%h cyc=%0d", mif.mem_addr, mif.if_rdata, cycle);
        @(posedge clk); #1;
        mif.if_req = 1'b0; mif.dm_req = 1'b0;
        dm_exp_q.delete();
      end
    end
    checks++; if (!i_done) begin errors++; $display("FAIL starve_timeout: got no if_ack want if_ack"); end
    checks++; if (d_grants != 4) begin errors++; $display("FAIL starve_d_grants: got %0d want 4", d_grants); end
    checks++; if (dut.starve_cnt_q !== 4'd0) begin errors++; $display("FAIL starve_cnt_clear: got %0d want 0", dut.starve_cnt_q); end
  endtask

  task automatic test_async_reset();
    bit seen, done;
    int acks;
    logic [31:0] exp;
    seen = 0; done = 0; acks = 0;
    wait_cycles = 10;
    @(posedge clk); #1;
    mif.dm_req = 1'b1; mif.dm_we = 1'b0; mif.dm_addr = 32'h1000_0010;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (mif.mem_req) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL areset_grant: got no mem_req want mem_req"); end
    #1 reset = 1'b1;
    #1;
    checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL areset_mem_req: got %b want 0 before edge", mif.mem_req); end
    mif.dm_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mif.dm_ack) acks++;
    end
    checks++; if (mif.dm_rdata !== 32'h0) begin errors++; $display("FAIL areset_dm_rdata: got %h want 0", mif.dm_rdata); end
    reset = 1'b0;
    wait_cycles = 2;
    if_exp_q.push_back(model_read(32'h0040_0300));
    @(posedge clk); #1;
    mif.if_req = 1'b1; mif.if_addr = 32'h0040_0300;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (mif.dm_ack) acks++;
      if (mif.if_ack) begin
        done = 1;
        exp = if_exp_q.pop_front();
        checks++; if (mif.if_rdata !== exp) begin errors++; $display("FAIL areset_if_rdata: got %h want %h", mif.if_rdata, exp); end
        $display("txn IF  addr=%h data=%h cyc=%0d", mif.mem_addr, mif.if_rdata, cycle);
        @(posedge clk); #1;
        mif.if_req = 1'b0;
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL areset_timeout: got no if_ack want if_ack"); end
    checks++; if (acks != 0) begin errors++; $display("FAIL areset_dm_ack: got %0d acks want 0", acks); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr, exp;
    int n, last;
    n = 0; last = 0;
    tie_ready = 1'b1; wait_cycles = 0;
    addr = 32'h0040_0400;
    if_exp_q.push_back(model_read(addr));
    @(posedge clk); #1;
    mif.if_req = 1'b1; mif.if_addr = addr;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clk);
      if (mif.if_ack) begin
        exp = if_exp_q.pop_front();
        checks++; if (mif.if_rdata !== exp) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h want %h", n, mif.if_rdata, exp); end
        if (n > 0) begin
          checks++; if (cycle - last != 2) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d want 2", n, cycle - last); end
        end
        $display("txn IF  addr=%h data=%h cyc=%0d", mif.mem_addr, mif.if_rdata, cycle);
        last = cycle;
        n++;
        @(posedge clk); #1;
        if (n < 6) begin
          addr = addr + 32'd4;
          mif.if_addr = addr;
          if_exp_q.push_back(model_read(addr));
        end else begin
          mif.if_req = 1'b0;
        end
      end
    end
    checks++; if (n != 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", n); end
    tie_ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    reset = 1'b1;
    mif.if_req = 1'b0; mif.if_addr = '0;
    mif.dm_req = 1'b0; mif.dm_we = 1'b0; mif.dm_addr = '0;
    mif.dm_wdata = '0; mif.dm_be = 4'h0;
    mem_model[32'h0040_0000] = 32'h2008_0005;
    mem_model[32'h1000_0004] = 32'h1122_3344;
    test_reset();
    test_single_fetch();
    test_store_load();
    test_collision();
    test_starvation();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified single-port memory between the instruction-fetch stage and the data-memory stage of the pipelined MIPS core.
- Arbitrates the two requesters and sequences each transaction through a request/ready handshake with the memory.
- Produces per-stage stall signals so the hazard logic can freeze the pipeline while an access is outstanding.
- Data-stage requests have priority; a starvation counter guarantees forward progress of instruction fetch.

Parameters:
- ADDR_W, 32, address width of both requesters and memory.
- DATA_W, 32, data width.
- STARVE_MAX, 4, max consecutive data grants while fetch is waiting before fetch is forced (1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  ADDR_W  fetch address, stable while if_req.
- if_rdata  out  DATA_W  fetched word.
- if_ack  out  1  fetch complete (single cycle).
- if_stall  out  1  if_req && !if_ack.
- dm_req  in  1  data request, held until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_be  in  4  byte enables for store.
- dm_rdata  out  DATA_W  load data.
- dm_ack  out  1  data access complete (single cycle).
- dm_stall  out  1  dm_req && !dm_ack.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  registered.
- mem_addr  out  ADDR_W  registered.
- mem_wdata  out  DATA_W  registered.
- mem_be  out  4  registered.
- mem_ready  in  1  memory completes current request this cycle.
- mem_rdata  in  DATA_W  read data, valid with mem_ready.

Behaviour:
- Reset (async, any state):
  - state = IDLE, starve_cnt = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0.
  - Held if_rdata and dm_rdata registers = 0; acks = 0.
  - An in-flight transaction is abandoned; no ack is issued for it.
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE, arbitration on each rising edge:
  - if dm_req && !(if_req && starve_cnt == STARVE_MAX): go to GRANT_D.
  - else if if_req: go to GRANT_I.
  - else stay in IDLE.
- Grant edge loads mem_* registers and sets mem_req = 1:
  - GRANT_I: mem_addr = if_addr, mem_we = 0, mem_be = 4'hf, mem_wdata unchanged.
  - GRANT_D: mem_addr = dm_addr, mem_we = dm_we, mem_be = dm_be, mem_wdata = dm_wdata.
- GRANT_x:
  - mem_req and all mem_* outputs are held stable until mem_ready.
  - x_ack = (state == GRANT_x) && mem_ready, combinational.
  - On that edge: next state IDLE, mem_req = 0 (mem_addr/we/be/wdata hold their values).
- Load/fetch data capture:
  - When acked, x_rdata = mem_rdata combinationally in the ack cycle; the held register is also loaded with mem_rdata.
  - Otherwise x_rdata = held value.
  - A store ack does not update dm_rdata.
- Latency: request sampled in IDLE at edge N → mem_req high in cycle N+1 → ack in the first cycle with mem_ready. Minimum is 2 cycles from req to ack with a zero-wait memory.
- Back-to-back: requester advances its address on the ack edge; the arbiter is in IDLE the next cycle and samples the new request. One idle bubble per transaction.
- starve_cnt:
  - On a GRANT_D edge where if_req = 1: increment, saturating at STARVE_MAX.
  - On a GRANT_I edge: clear to 0.
  - On a GRANT_D edge with if_req = 0: unchanged.
- Simultaneous if_req and dm_req:
  - D wins unless starve_cnt == STARVE_MAX, in which case I wins.
- mem_ready while in IDLE is ignored.
- Requester dropping req mid-transaction is a protocol violation: the transaction still completes and the ack is still issued.
- Stalls are combinational from req and ack; no stall asserts when req = 0.

Test Plan:
- Single fetch:
  - Stimulus: if_req = 1, if_addr = 0x0040_0000; memory returns 0x2008_0005 with ready 2 cycles after mem_req.
  - Required: mem_addr = 0x0040_0000, mem_be = 0xf, mem_we = 0; if_ack pulses once; if_rdata = 0x2008_0005 and held after the ack.
- Store then load:
  - Stimulus: dm_we = 1, dm_addr = 0x1000_0004, dm_wdata = 0xDEAD_BEEF, dm_be = 0x3; then a load from the same address.
  - Required: mem_wdata = 0xDEAD_BEEF and mem_be = 0x3 during the store; dm_rdata is unchanged by the store; on the load, dm_rdata = the value the memory returns.
- Collision:
  - Stimulus: if_req and dm_req rise in the same cycle.
  - Required: D granted first; I granted after dm_ack plus one IDLE cycle; if_stall stays high throughout.
- Starvation:
  - Stimulus: STARVE_MAX = 4; dm_req continuously asserted with a fresh address each ack; if_req held.
  - Required: exactly 4 D grants, then 1 I grant; starve_cnt = 0 afterwards.
- Async reset mid-transaction:
  - Stimulus: assert reset while in GRANT_D with mem_ready low.
  - Required: mem_req = 0 immediately, without waiting for a clock edge; no dm_ack; after release, IDLE accepts a new request normally.
- Zero-wait memory:
  - Stimulus: mem_ready tied high; if_req held with an incrementing address.
  - Required: if_ack every 2nd cycle; each ack's if_rdata matches its address.
